pcie_line_scheduler: RTL

// Ping-pong line-buffer scheduler between the video line writer and the PCIe DMA reader, all on sys_clk.
// It hands the writer a free buffer, tracks which buffers are full, and requests one DMA line transfer per full buffer.

---
 rtl/pcie_line_scheduler_if.sv | 36 +++
 rtl/pcie_line_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pcie_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// pcie_line_scheduler_if
// Writer/DMA-side signal bundle for the ping-pong line scheduler.
// Rev 1.0
// ============================================================================
interface pcie_line_scheduler_if;
   logic        enable;
   logic        wr_line_done;
   logic        wr_buf_sel;
   logic        wr_buf_ready;
   logic        dma_req;
   logic        dma_ack;
   logic        rd_ready;
   logic        rd_en;
   logic        rd_buf_sel;
   logic [11:0] rd_addr;
   logic [15:0] line_idx;
   logic        frame_start;
   logic        frame_end;
   logic        overflow;
   logic [15:0] drop_cnt;

   modport master (
      output enable, wr_line_done, dma_ack, rd_ready,
      input  wr_buf_sel, wr_buf_ready, dma_req, rd_en, rd_buf_sel, rd_addr,
             line_idx, frame_start, frame_end, overflow, drop_cnt
   );

   modport slave (
      input  enable, wr_line_done, dma_ack, rd_ready,
      output wr_buf_sel, wr_buf_ready, dma_req, rd_en, rd_buf_sel, rd_addr,
             line_idx, frame_start, frame_end, overflow, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pcie_line_scheduler.sv
`default_nettype none
// ============================================================================
// pcie_line_scheduler
// Ping-pong line-buffer scheduler between a line writer and a PCIe DMA reader.
// Rev 1.0
// ============================================================================
module pcie_line_scheduler #(
   parameter int LINE_WORDS  = 1920,
   parameter int FRAME_LINES = 1080
) (
   input  wire logic             sys_clk_i,
   input  wire logic             sys_rst_i,
   pcie_line_scheduler_if.slave  bus
);

   localparam logic [11:0] c_LAST_ADDR = 12'(LINE_WORDS - 1);
   localparam logic [15:0] c_LAST_LINE = 16'(FRAME_LINES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      READ = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  full_q, full_d;
   logic        wr_sel_q, wr_sel_d;
   logic        rd_sel_q, rd_sel_d;
   logic [11:0] rd_addr_q, rd_addr_d;
   logic [15:0] line_idx_q, line_idx_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        overflow_q, overflow_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_end_q, frame_end_d;
   logic        w_rd_en;
   logic        w_dma_req;

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q       <= IDLE;
         full_q        <= 2'b00;
         wr_sel_q      <= 1'b0;
         rd_sel_q      <= 1'b0;
         rd_addr_q     <= 12'd0;
         line_idx_q    <= 16'd0;
         drop_cnt_q    <= 16'd0;
         overflow_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         full_q        <= full_d;
         wr_sel_q      <= wr_sel_d;
         rd_sel_q      <= rd_sel_d;
         rd_addr_q     <= rd_addr_d;
         line_idx_q    <= line_idx_d;
         drop_cnt_q    <= drop_cnt_d;
         overflow_q    <= overflow_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      full_d        = full_q;
      wr_sel_d      = wr_sel_q;
      rd_sel_d      = rd_sel_q;
      rd_addr_d     = rd_addr_q;
      line_idx_d    = line_idx_q;
      drop_cnt_d    = drop_cnt_q;
      overflow_d    = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      w_rd_en       = 1'b0;
      w_dma_req     = 1'b0;

      // Writer side uses pre-DONE occupancy; read and write buffers never coincide.
      if (bus.wr_line_done) begin
         if (!full_q[wr_sel_q]) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end else begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.enable && full_q[rd_sel_q]) begin
               state_d = REQ;
            end
         end
         REQ: begin
            w_dma_req = 1'b1;
            if (bus.dma_ack) begin
               state_d       = READ;
               rd_addr_d     = 12'd0;
               frame_start_d = (line_idx_q == 16'd0);
            end
         end
         READ: begin
            w_rd_en = bus.rd_ready;
            if (bus.rd_ready) begin
               if (rd_addr_q == c_LAST_ADDR) begin
                  state_d     = DONE;
                  frame_end_d = (line_idx_q == c_LAST_LINE);
               end else begin
                  rd_addr_d = rd_addr_q + 12'd1;
               end
            end
         end
         DONE: begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            line_idx_d       = (line_idx_q == c_LAST_LINE) ? 16'd0 : line_idx_q + 16'd1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.wr_buf_sel   = wr_sel_q;
   assign bus.wr_buf_ready = ~full_q[wr_sel_q];
   assign bus.dma_req      = w_dma_req;
   assign bus.rd_en        = w_rd_en;
   assign bus.rd_buf_sel   = rd_sel_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.line_idx     = line_idx_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.frame_end    = frame_end_q;
   assign bus.overflow     = overflow_q;
   assign bus.drop_cnt     = drop_cnt_q;

endmodule
`default_nettype wire
